// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the 4:1 mux select sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_scan_ctrl_pkg;

   // Number of mux inputs being scanned and the select width they need.
   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   // Scan FSM encodings.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2
   } state_e;

endpackage

// File: rtl/mux_scan_ctrl_next_ch.sv
// Picks the next enabled channel strictly above cur_ch, wrapping 3->0.
// Latency: combinational.
// Backpressure: none. A mask with only cur_ch set returns cur_ch; an empty mask returns cur_ch.
module mux_scan_next_ch
   import mux_scan_ctrl_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [CH_W-1:0]   cur_ch,
   output logic [CH_W-1:0]   nxt_ch
);

   logic [CH_W-1:0] cand;
   logic            found;

   // Ascending search starting one above cur_ch; cur_ch itself is the last candidate.
   always_comb begin
      nxt_ch = cur_ch;
      found  = 1'b0;
      cand   = cur_ch;
      for (int i = 1; i <= NUM_CH; i++) begin
         cand = cur_ch + CH_W'(i);
         if (!found && mask[cand]) begin
            nxt_ch = cand;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Select sequencer for a 4:1 mux: settles each enabled input for max(dwell,1) cycles, then strobes a sample.
// Latency: start cycle 0 -> select cycle 1 -> sample_valid cycle D+1; per-channel period D+1.
// Backpressure: none; start ignored while busy, stop wins over start. Optional capture via MUX_SCAN_CAPTURE_EN.
module mux_scan_ctrl
   import mux_scan_ctrl_pkg::*;
#(
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [3:0]         chan_mask,
   input  logic [DWELL_W-1:0] dwell,
`ifdef MUX_SCAN_CAPTURE_EN
   input  logic               op_in,
   output logic [3:0]         frame,
   output logic               frame_valid,
`endif
   output logic               s0,
   output logic               s1,
   output logic [1:0]         chan_idx,
   output logic               sample_valid,
   output logic               sweep_done,
   output logic               busy
);

   state_e             state_q, state_d;
   logic [CH_W-1:0]    chan_q, chan_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0]  mask_q, mask_d;
   logic               sample_valid_q, sample_valid_d;
   logic               sweep_done_q, sweep_done_d;
   logic               busy_q, busy_d;

   logic [CH_W-1:0]    nxt_ch;
   logic [CH_W-1:0]    first_ch;
   logic               last_ch;
   logic [DWELL_W-1:0] dwell_ld;
   logic               start_go;

   // Next channel within the sweep, using the mask latched for this sweep.
   mux_scan_next_ch u_next_ch (
      .mask   (mask_q),
      .cur_ch (chan_q),
      .nxt_ch (nxt_ch)
   );

   // Lowest enabled channel of the live mask: search from 3 so the wrap lands on 0 first.
   mux_scan_next_ch u_first_ch (
      .mask   (chan_mask),
      .cur_ch (2'd3),
      .nxt_ch (first_ch)
   );

   // Current channel is the highest enabled one when the ascending search wraps (or finds only itself).
   assign last_ch  = (nxt_ch <= chan_q);
   // Counter counts down to zero, so load D-1 with dwell 0 treated as 1.
   assign dwell_ld = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
   assign start_go = (state_q == ST_IDLE) && start && !stop && (chan_mask != '0);

   // Next-state and registered-output computation for the scan FSM.
   always_comb begin
      state_d        = state_q;
      chan_d         = chan_q;
      cnt_d          = cnt_q;
      mask_d         = mask_q;
      sample_valid_d = 1'b0;
      sweep_done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_go) begin
               state_d = ST_SETTLE;
               chan_d  = first_ch;
               mask_d  = chan_mask;
               cnt_d   = dwell_ld;
            end
         end
         ST_SETTLE: begin
            if (stop) begin
               state_d = ST_IDLE;
               chan_d  = '0;
            end else if (cnt_q == '0) begin
               state_d        = ST_SAMPLE;
               sample_valid_d = 1'b1;
               sweep_done_d   = last_ch;
            end else begin
               cnt_d = cnt_q - DWELL_W'(1);
            end
         end
         ST_SAMPLE: begin
            if (stop) begin
               state_d = ST_IDLE;
               chan_d  = '0;
            end else if (last_ch) begin
               // Sweep wrap: the only point where a new mask is accepted.
               mask_d = chan_mask;
               if (chan_mask == '0) begin
                  state_d = ST_IDLE;
                  chan_d  = '0;
               end else begin
                  state_d = ST_SETTLE;
                  chan_d  = first_ch;
                  cnt_d   = dwell_ld;
               end
            end else begin
               state_d = ST_SETTLE;
               chan_d  = nxt_ch;
               cnt_d   = dwell_ld;
            end
         end
         default: begin
            state_d = ST_IDLE;
            chan_d  = '0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Scan FSM state and its registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         chan_q         <= '0;
         cnt_q          <= '0;
         mask_q         <= '0;
         sample_valid_q <= 1'b0;
         sweep_done_q   <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         chan_q         <= chan_d;
         cnt_q          <= cnt_d;
         mask_q         <= mask_d;
         sample_valid_q <= sample_valid_d;
         sweep_done_q   <= sweep_done_d;
         busy_q         <= busy_d;
      end
   end

   assign s0           = chan_q[0];
   assign s1           = chan_q[1];
   assign chan_idx     = chan_q;
   assign sample_valid = sample_valid_q;
   assign sweep_done   = sweep_done_q;
   assign busy         = busy_q;

`ifdef MUX_SCAN_CAPTURE_EN
   logic [NUM_CH-1:0] frame_q, frame_d;
   logic              frame_valid_q, frame_valid_d;

   // Capture op_in into the current channel's bit on every sample; bits outside the sweep mask read 0.
   always_comb begin
      frame_d       = frame_q;
      frame_valid_d = sweep_done_q;
      if (start_go) begin
         frame_d = '0;
      end else if (sample_valid_q) begin
         frame_d[chan_q] = op_in;
         frame_d         = frame_d & mask_q;
      end
   end

   // Capture frame register; frame_valid follows sweep_done by one cycle so the last bit is in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_q       <= '0;
         frame_valid_q <= 1'b0;
      end else begin
         frame_q       <= frame_d;
         frame_valid_q <= frame_valid_d;
      end
   end

   assign frame       = frame_q;
   assign frame_valid = frame_valid_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl; build with MUX_SCAN_CAPTURE_EN to also exercise frame capture.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Expected values are hand-derived per cycle; cycle 0 is the cycle in which start is held high.
module tb_mux_scan_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic [3:0] chan_mask;
   logic [3:0] dwell;
   logic       s0;
   logic       s1;
   logic [1:0] chan_idx;
   logic       sample_valid;
   logic       sweep_done;
   logic       busy;
`ifdef MUX_SCAN_CAPTURE_EN
   logic       op_in;
   logic [3:0] frame;
   logic       frame_valid;
   logic [3:0] pat;
`endif

   int n_cmp;
   int n_err;

   mux_scan_ctrl #(.DWELL_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .chan_mask    (chan_mask),
      .dwell        (dwell),
`ifdef MUX_SCAN_CAPTURE_EN
      .op_in        (op_in),
      .frame        (frame),
      .frame_valid  (frame_valid),
`endif
      .s0           (s0),
      .s1           (s1),
      .chan_idx     (chan_idx),
      .sample_valid (sample_valid),
      .sweep_done   (sweep_done),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed outputs packed as {busy, sweep_done, sample_valid, s1, s0, chan_idx}.
   logic [6:0] ov;
   assign ov = {busy, sweep_done, sample_valid, s1, s0, chan_idx};

   function automatic logic [6:0] ev(input logic b, input logic sd, input logic sv, input logic [1:0] ch);
      return {b, sd, sv, ch[1], ch[0], ch};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst       = 1'b1;
      start     = 1'b0;
      stop      = 1'b0;
      chan_mask = 4'h0;
      dwell     = 4'd0;
`ifdef MUX_SCAN_CAPTURE_EN
      op_in     = 1'b0;
      pat       = 4'b1101;
`endif
      step();
      step();
      chk("reset_outs", ov, ev(1'b0, 1'b0, 1'b0, 2'd0));
      rst = 1'b0;
      step();
      chk("post_reset_idle", ov, ev(1'b0, 1'b0, 1'b0, 2'd0));

      // T2: all channels, dwell 3 -> period 4, samples at cycles 4,8,12,16, sweep_done at 16.
      chan_mask = 4'b1111;
      dwell     = 4'd3;
      start     = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         chk($sformatf("T2_c%0d", c), ov,
             ev(1'b1, (c == 16), (c % 4 == 0), 2'((c - 1) / 4)));
         step();
      end
      chk("T2_c17_wrap_ch0", ov, ev(1'b1, 1'b0, 1'b0, 2'd0));
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("T2_stop_idle", ov, ev(1'b0, 1'b0, 1'b0, 2'd0));

      // T3: mask 1010, dwell 0 -> ch1,ch3 alternately, sample every other cycle; stop in SAMPLE.
      chan_mask = 4'b1010;
      dwell     = 4'd0;
      start     = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         chk($sformatf("T3_c%0d", c), ov,
             ev(1'b1, (c % 4 == 0), (c % 2 == 0), ((((c - 1) / 2) % 2) == 1) ? 2'd3 : 2'd1));
         if (c == 8) stop = 1'b1;
         step();
      end
      stop = 1'b0;
      chk("T3_stop_in_sample_idle", ov, ev(1'b0, 1'b0, 1'b0, 2'd0));

      // T4: dwell 2; stop during ch2 SETTLE (cycle 7) -> idle at cycle 8, no ch2 sample.
      chan_mask = 4'b1111;
      dwell     = 4'd2;
      start     = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         chk($sformatf("T4_c%0d", c), ov,
             ev(1'b1, 1'b0, (c % 3 == 0), 2'((c - 1) / 3)));
         if (c == 7) stop = 1'b1;
         step();
      end
      stop = 1'b0;
      chk("T4_stop_settle_idle", ov, ev(1'b0, 1'b0, 1'b0, 2'd0));
      step();
      chk("T4_no_late_sample", ov, ev(1'b0, 1'b0, 1'b0, 2'd0));
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      chk("T4_start_stop_same", ov, ev(1'b0, 1'b0, 1'b0, 2'd0));
      chan_mask = 4'b0000;
      start     = 1'b1;
      step();
      start = 1'b0;
      chk("T4_start_mask0", ov, ev(1'b0, 1'b0, 1'b0, 2'd0));

      // T5: mask 1111 -> 0001 mid-sweep; sweep finishes ch3, then ch0 only; mask 0 at wrap -> idle.
      chan_mask = 4'b1111;
      dwell     = 4'd1;
      start     = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         chk($sformatf("T5_c%0d", c), ov,
             ev(1'b1, (c % 2 == 0) && (c >= 8), (c % 2 == 0), (c <= 8) ? 2'((c - 1) / 2) : 2'd0));
         if (c == 3)  chan_mask = 4'b0001;
         if (c == 12) chan_mask = 4'b0000;
         step();
      end
      chk("T5_mask0_wrap_idle", ov, ev(1'b0, 1'b0, 1'b0, 2'd0));

      // T1: async reset mid-scan clears outputs without waiting for a clock edge.
      chan_mask = 4'b1111;
      dwell     = 4'd3;
      start     = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      chk("T1_busy_before_rst", ov, ev(1'b1, 1'b0, 1'b0, 2'd0));
      step();
      step();
      chk("T1_ch1_before_rst", ov, ev(1'b1, 1'b0, 1'b0, 2'd1));
      #2;
      rst = 1'b1;
      #1;
      chk("T1_async_clear", ov, ev(1'b0, 1'b0, 1'b0, 2'd0));
      step();
      rst = 1'b0;
      step();
      step();
      chk("T1_stays_idle", ov, ev(1'b0, 1'b0, 1'b0, 2'd0));

`ifdef MUX_SCAN_CAPTURE_EN
      // T6: op_in 1,0,1,1 on ch0..3 -> frame 1101 with frame_valid the cycle after sweep_done.
      chk("T6_frame_reset", {28'd0, frame}, 32'h0);
      chan_mask = 4'b1111;
      dwell     = 4'd1;
      start     = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         op_in = pat[2'((c - 1) / 2)];
         if (c == 8) chk("T6_sweep_done", {31'd0, sweep_done}, 32'd1);
         chk($sformatf("T6_fv_low_c%0d", c), {31'd0, frame_valid}, 32'd0);
         step();
      end
      op_in = 1'b0;
      chk("T6_frame_valid", {31'd0, frame_valid}, 32'd1);
      chk("T6_frame", {28'd0, frame}, 32'hD);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("T6_frame_valid_pulse", {31'd0, frame_valid}, 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("T6_frame_cleared_on_start", {28'd0, frame}, 32'h0);
      stop = 1'b1;
      step();
      stop = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
